// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: a FETCH/EXEC/HALT sequencer that owns the program counter,
// latches each instruction with its fetch address and resolves zero-flag jumps.
module instr_fetch_unit #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero_flag,
  input  logic               stall,
  output logic [ADDR_W-1:0]  address,
  output logic [INSTR_W-1:0] instr_reg,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               exec_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0]   instr_reg_q, instr_reg_d;
  logic                 jump;
  logic [ADDR_W-1:0]    target;

  assign jump   = (instr_reg_q[7:6] == 2'b10);
  assign target = instr_reg_q[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_pc_d  = instr_pc_q;
    instr_reg_d = instr_reg_q;
    case (state_q)
      FETCH: begin
        if (run) begin
          instr_reg_d = instruction;
          instr_pc_d  = pc_q;
          pc_d        = pc_q + ADDR_W'(1);
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          // A taken jump back onto its own address is the program's halt idiom.
          if (jump && zero_flag) begin
            pc_d    = target;
            state_d = (target == instr_pc_q) ? HALT : FETCH;
          end else begin
            state_d = FETCH;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      instr_pc_q  <= '0;
      instr_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_pc_q  <= instr_pc_d;
      instr_reg_q <= instr_reg_d;
    end
  end

  assign address    = pc_q;
  assign instr_reg  = instr_reg_q;
  assign instr_pc   = instr_pc_q;
  assign exec_valid = (state_q == EXEC);
  assign halted     = (state_q == HALT);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: ADDR_W, 4, program-counter and instruction-address width.
REQ-002 Parameter: INSTR_W, 8, instruction width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: run  input  1  fetch enable; low holds the unit in FETCH with no capture.
REQ-006 Port: instruction  input  INSTR_W  combinational read data from program memory for the current address.
REQ-007 Port: zero_flag  input  1  datapath zero flag, sampled only in EXEC.
REQ-008 Port: stall  input  1  datapath hold request, honoured only in EXEC.
REQ-009 Port: address  output  ADDR_W  program-memory read address; always equals the PC register.
REQ-010 Port: instr_reg  output  INSTR_W  latched instruction under execution.
REQ-011 Port: instr_pc  output  ADDR_W  address from which instr_reg was fetched.
REQ-012 Port: exec_valid  output  1  high during every EXEC cycle; instr_reg is valid to the datapath.
REQ-013 Port: halted  output  1  high while in HALT.

Function
REQ-014 The FSM SHALL have three states: FETCH, EXEC and HALT.
REQ-015 FETCH with run=1: instr_reg <= instruction; instr_pc <= PC; PC <= PC+1 modulo 2^ADDR_W (15 wraps to 0); next state EXEC.
REQ-016 FETCH with run=0: all registers hold; state stays FETCH; exec_valid=0.
REQ-017 EXEC with stall=1: all registers hold; state stays EXEC; exec_valid stays 1; zero_flag is ignored.
REQ-018 EXEC with stall=0: the unit decodes the jump field: jump = (instr_reg[7:6] == 2'b10); target = instr_reg[3:0].
REQ-019 EXEC, stall=0, jump=1, zero_flag=1, target != instr_pc: PC <= target; next state FETCH.
REQ-020 EXEC, stall=0, jump=1, zero_flag=1, target == instr_pc: PC <= target; next state HALT.
REQ-021 EXEC, stall=0, jump=0 or zero_flag=0: PC keeps the incremented value; next state FETCH.
REQ-022 HALT: all registers hold; halted=1; exec_valid=0; HALT is left only by reset; run, stall and zero_flag are ignored.
REQ-023 Unstalled throughput: one instruction per 2 cycles; fetch-to-exec_valid latency is 1 cycle.
REQ-024 exec_valid and halted SHALL be decoded from the state register only, with no combinational path from any input.
REQ-025 address SHALL depend only on the PC register, with no combinational path from instruction, zero_flag or stall.
REQ-026 run is sampled only in FETCH; deasserting run during EXEC does not abort the current instruction.

Reset
REQ-027 reset=1 at a clock edge SHALL force: state FETCH; PC=0; address=0; instr_reg=8'h00; instr_pc=0; exec_valid=0; halted=0.
REQ-028 Reset SHALL take priority over run, stall and every FSM state, including mid-EXEC with stall=1 and HALT.
REQ-029 The reset effect is visible on the cycle after the sampling edge; no asynchronous path exists.

Verification
REQ-030 Reset, then run=1 with memory 0->8'h08, 1->8'h19 -> cycle 1: instr_reg=8'h08, instr_pc=0, exec_valid=1, address=1; cycle 3: instr_reg=8'h19, instr_pc=1.
REQ-031 PC=15, run=1 -> after FETCH, instr_pc=15 and address=0; the EXEC of a non-jump returns to FETCH at address 0.
REQ-032 instr_reg=8'hB2 at instr_pc=8, zero_flag=1 -> next FETCH address=2. Repeat with zero_flag=0 -> next FETCH address=9.
REQ-033 instr_reg=8'hB8 at instr_pc=8, zero_flag=1 -> halted=1, exec_valid=0, address=8; state persists 20+ cycles under any run/stall/zero_flag; reset clears it.
REQ-034 stall=1 for 3 cycles in EXEC -> exec_valid high for 4 consecutive cycles; PC, instr_reg and instr_pc unchanged throughout; a zero_flag toggle during the stall has no effect.
REQ-035 reset pulsed in EXEC with stall=1, and separately in HALT -> next cycle: all outputs at reset values (REQ-027); FETCH restarts from address 0.
